// File: rtl/mission_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mission_sequencer
// Purpose  : Table-driven rover mission sequencer. Steps through NUM_STAGES
//            stages: wait for a gate event, wait a pre-delay, then enable the
//            colour sensor until the stage's target colour is seen. A hit
//            applies the stage speed and advances. A timeout in LOOK counts a
//            miss, and MAX_RETRY misses end in FAULT. abort returns to IDLE.
// Ports    : clock, reset (async, active-high)
//            go, abort               - mission start / return-to-idle levels
//            color_hit[NUM_COLORS]   - colour-sensor feedback (0 red,1 grn,2 blu)
//            gate_in[NUM_GATES]      - gate events
//            color_enable, speed, direction - actuator requests (registered)
//            state, stage_idx, retry_cnt, sec_count, done, fault - status
//            obj_detect / led_obj    - only when OBJ_PAUSE_EN is defined
// Options  : OBJ_PAUSE_EN - obstacle pause. While obj_detect is high, speed
//            reads 0 and the FSM and timers freeze.
// Revision : 1.0 - initial release
// ============================================================================
module mission_sequencer #(
    parameter int unsigned                    TICK_CYCLES = 100000000,
    parameter int unsigned                    NUM_STAGES  = 3,
    parameter int unsigned                    NUM_COLORS  = 3,
    parameter int unsigned                    NUM_GATES   = 2,
    parameter int unsigned                    SPEED_W     = 2,
    parameter logic [2*NUM_STAGES-1:0]        STAGE_COLOR = 6'b00_10_01,
    parameter logic [SPEED_W*NUM_STAGES-1:0]  STAGE_SPEED = 6'b00_01_10,
    parameter logic [2*NUM_STAGES-1:0]        STAGE_GATE  = 6'b11_01_11,
    parameter logic [4*NUM_STAGES-1:0]        STAGE_DELAY = 12'hA00,
    parameter logic [NUM_STAGES-1:0]          STAGE_DIR   = 3'b011,
    parameter int unsigned                    TIMEOUT_S   = 3,
    parameter int unsigned                    MAX_RETRY   = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  go,
    input  logic                  abort,
    input  logic [NUM_COLORS-1:0] color_hit,
    input  logic [NUM_GATES-1:0]  gate_in,
`ifdef OBJ_PAUSE_EN
    input  logic                  obj_detect,
    output logic                  led_obj,
`endif
    output logic                  color_enable,
    output logic [SPEED_W-1:0]    speed,
    output logic                  direction,
    output logic [2:0]            state,
    output logic [2:0]            stage_idx,
    output logic [1:0]            retry_cnt,
    output logic [3:0]            sec_count,
    output logic                  done,
    output logic                  fault
);

    localparam int unsigned           c_TICK_W     = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [c_TICK_W-1:0]   c_TICK_MAX   = c_TICK_W'(TICK_CYCLES - 1);
    localparam logic [3:0]            c_TIMEOUT    = 4'(TIMEOUT_S);
    localparam logic [2:0]            c_MAX_RETRY  = 3'(MAX_RETRY);
    localparam logic [2:0]            c_LAST_STAGE = 3'(NUM_STAGES - 1);
    localparam logic [2:0]            c_NUM_GATES  = 3'(NUM_GATES);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_GATE    = 3'd1,
        S_DELAY   = 3'd2,
        S_LOOK    = 3'd3,
        S_BACKOFF = 3'd4,
        S_DONE    = 3'd5,
        S_FAULT   = 3'd6
    } state_t;

    state_t                r_state;
    logic [2:0]            r_stage;
    logic [1:0]            r_retry;
    logic [c_TICK_W-1:0]   r_tick;
    logic [3:0]            r_sec;
    logic                  r_color_en;
    logic [SPEED_W-1:0]    r_speed;
    logic                  r_dir;
    logic                  r_done;
    logic                  r_fault;
    logic                  r_led;

    // Stage tables are padded to 8 entries so the 3-bit stage index always
    // selects a defined entry.
    logic [1:0]            w_color_tab [8];
    logic [SPEED_W-1:0]    w_speed_tab [8];
    logic [1:0]            w_gate_tab  [8];
    logic [3:0]            w_delay_tab [8];
    logic                  w_dir_tab   [8];

    for (genvar g = 0; g < 8; g++) begin : g_stage_tab
        if (g < NUM_STAGES) begin : g_used
            assign w_color_tab[g] = STAGE_COLOR[2*g +: 2];
            assign w_speed_tab[g] = STAGE_SPEED[SPEED_W*g +: SPEED_W];
            assign w_gate_tab[g]  = STAGE_GATE[2*g +: 2];
            assign w_delay_tab[g] = STAGE_DELAY[4*g +: 4];
            assign w_dir_tab[g]   = STAGE_DIR[g];
        end else begin : g_unused
            assign w_color_tab[g] = '0;
            assign w_speed_tab[g] = '0;
            assign w_gate_tab[g]  = '0;
            assign w_delay_tab[g] = '0;
            assign w_dir_tab[g]   = 1'b0;
        end
    end

    // Zero-extended sensor/gate vectors: a table index beyond the real width
    // reads as "never seen" for colours. Gate indices at or above NUM_GATES
    // mean "no gate" and pass immediately.
    logic [3:0] w_hit_ext;
    logic [3:0] w_gate_ext;
    logic       w_hit;
    logic       w_gate_pass;
    logic [2:0] w_retry_inc;
    logic       w_pause;

    assign w_hit_ext   = 4'(color_hit);
    assign w_gate_ext  = 4'(gate_in);
    assign w_hit       = w_hit_ext[w_color_tab[r_stage]];
    assign w_gate_pass = ({1'b0, w_gate_tab[r_stage]} >= c_NUM_GATES) ||
                         w_gate_ext[w_gate_tab[r_stage]];
    assign w_retry_inc = {1'b0, r_retry} + 3'd1;

`ifdef OBJ_PAUSE_EN
    assign w_pause = obj_detect;
    assign led_obj = r_led;
    // The stored speed is kept and only masked, so motion resumes unchanged.
    assign speed   = r_led ? '0 : r_speed;
`else
    assign w_pause = 1'b0;
    assign speed   = r_speed;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_stage    <= '0;
            r_retry    <= '0;
            r_tick     <= '0;
            r_sec      <= '0;
            r_color_en <= 1'b0;
            r_speed    <= '0;
            r_dir      <= 1'b0;
            r_done     <= 1'b0;
            r_fault    <= 1'b0;
            r_led      <= 1'b0;
        end else begin
            r_led <= w_pause;
            if (abort && (r_state != S_IDLE)) begin
                r_state    <= S_IDLE;
                r_tick     <= '0;
                r_sec      <= '0;
                r_color_en <= 1'b0;
                r_speed    <= '0;
                r_dir      <= 1'b0;
                r_done     <= 1'b0;
                r_fault    <= 1'b0;
            end else if (!w_pause) begin
                // Free-running time base; every transition below overrides
                // this with a clear so sec_count is time-in-state.
                if (r_tick == c_TICK_MAX) begin
                    r_tick <= '0;
                    if (r_sec != 4'hF) begin
                        r_sec <= r_sec + 4'd1;
                    end
                end else begin
                    r_tick <= r_tick + c_TICK_W'(1);
                end

                case (r_state)
                    S_IDLE: begin
                        if (go) begin
                            r_stage <= '0;
                            r_retry <= '0;
                            r_state <= S_GATE;
                            r_tick  <= '0;
                            r_sec   <= '0;
                        end
                    end
                    S_GATE: begin
                        if (w_gate_pass) begin
                            r_dir   <= w_dir_tab[r_stage];
                            r_state <= S_DELAY;
                            r_tick  <= '0;
                            r_sec   <= '0;
                        end
                    end
                    S_DELAY: begin
                        if (r_sec == w_delay_tab[r_stage]) begin
                            r_color_en <= 1'b1;
                            r_state    <= S_LOOK;
                            r_tick     <= '0;
                            r_sec      <= '0;
                        end
                    end
                    S_LOOK: begin
                        // Hit is tested first so it wins over a coincident timeout.
                        if (w_hit) begin
                            r_color_en <= 1'b0;
                            r_speed    <= w_speed_tab[r_stage];
                            r_retry    <= '0;
                            r_tick     <= '0;
                            r_sec      <= '0;
                            if (r_stage == c_LAST_STAGE) begin
                                r_done  <= 1'b1;
                                r_state <= S_DONE;
                            end else begin
                                r_stage <= r_stage + 3'd1;
                                r_state <= S_GATE;
                            end
                        end else if (r_sec == c_TIMEOUT) begin
                            r_color_en <= 1'b0;
                            r_retry    <= w_retry_inc[1:0];
                            r_tick     <= '0;
                            r_sec      <= '0;
                            if (w_retry_inc >= c_MAX_RETRY) begin
                                r_speed <= '0;
                                r_fault <= 1'b1;
                                r_state <= S_FAULT;
                            end else begin
                                r_state <= S_BACKOFF;
                            end
                        end
                    end
                    S_BACKOFF: begin
                        // One second with the sensor off re-arms it.
                        if (r_sec == 4'd1) begin
                            r_color_en <= 1'b1;
                            r_state    <= S_LOOK;
                            r_tick     <= '0;
                            r_sec      <= '0;
                        end
                    end
                    S_DONE, S_FAULT: begin
                        // Terminal: outputs hold until abort or reset.
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_tick  <= '0;
                        r_sec   <= '0;
                    end
                endcase
            end
        end
    end

    assign state        = r_state;
    assign stage_idx    = r_stage;
    assign retry_cnt    = r_retry;
    assign sec_count    = r_sec;
    assign color_enable = r_color_en;
    assign direction    = r_dir;
    assign done         = r_done;
    assign fault        = r_fault;

endmodule
`default_nettype wire

// File: doc/mission_sequencer.md
Name: mission_sequencer

Overview:
Parametrised successor to the rover's colour-sensor mission state machine. It steps through a compile-time table of NUM_STAGES stages. Each stage waits for a gate event, waits a pre-delay, then enables the colour sensor until the stage's target colour is seen. On a hit it applies the stage's speed code and direction. Adds per-stage timeout with bounded retry, abort, and explicit DONE/FAULT status. It sits between the go switch, arm/obstacle logic and colour-sensor feedback, and drives the motor speed selector and colour-sensor enable.

Parameters:
TICK_CYCLES, 100000000, clock cycles per 1 s tick
NUM_STAGES, 3, number of mission stages (1..8)
NUM_COLORS, 3, width of color_hit (index 0 red, 1 green, 2 blue)
NUM_GATES, 2, width of gate_in; gate index NUM_GATES and above means no gate (immediate)
SPEED_W, 2, speed code width
STAGE_COLOR, 6'b00_10_01, 2 bits per stage, target colour index, stage 0 in LSBs
STAGE_SPEED, 6'b00_01_10, SPEED_W bits per stage, speed applied on hit
STAGE_GATE, 6'b11_01_11, 2 bits per stage, gate_in index to wait on
STAGE_DELAY, 12'hA00, 4 bits per stage, seconds between gate and colour enable
STAGE_DIR, 3'b011, 1 bit per stage, direction applied when the gate passes
TIMEOUT_S, 3, seconds in LOOK before a miss
MAX_RETRY, 2, misses allowed per stage before FAULT

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
go  in  1  mission start (level)
abort  in  1  return to IDLE (level)
color_hit  in  NUM_COLORS  colour-sensor feedback, one bit per colour
gate_in  in  NUM_GATES  gate events (bit0 arm_flag, bit1 left arm cleared)
color_enable  out  1  colour sensor look request
speed  out  SPEED_W  speed code to motor block
direction  out  1  steering/direction select
state  out  3  0 IDLE, 1 GATE, 2 DELAY, 3 LOOK, 4 BACKOFF, 5 DONE, 6 FAULT
stage_idx  out  3  current stage
retry_cnt  out  2  misses in current stage
sec_count  out  4  seconds elapsed in current state, saturating at 15
done  out  1  high in DONE
fault  out  1  high in FAULT

Behaviour:
- Reset (async) forces every output to 0, the state to IDLE, and the tick counter to 0.
- Tick counter: counts 0..TICK_CYCLES-1; on wrap, sec_count increments (saturates at 15). Both clear on every state transition.
- IDLE: on go=1, clear stage_idx and retry_cnt, then go to GATE.
- GATE: pass when STAGE_GATE[s] >= NUM_GATES, or when gate_in[STAGE_GATE[s]]=1. On pass, direction<=STAGE_DIR[s] and go to DELAY.
- DELAY: when sec_count==STAGE_DELAY[s], go to LOOK. A delay of 0 exits on the next cycle.
- LOOK: color_enable=1.
  - Hit (color_hit[STAGE_COLOR[s]]=1): color_enable<=0, speed<=STAGE_SPEED[s], retry_cnt<=0. If s==NUM_STAGES-1, go to DONE; otherwise s<=s+1 and go to GATE.
  - Miss (sec_count==TIMEOUT_S with no hit): color_enable<=0, retry_cnt+1. If the new count reaches MAX_RETRY, speed<=0 and go to FAULT; otherwise go to BACKOFF.
  - Hit and timeout in the same cycle: the hit wins.
- BACKOFF: color_enable=0 for 1 s (sec_count==1), then LOOK. This re-arms the sensor.
- DONE/FAULT: hold all outputs; done or fault=1. Exit only via abort or reset.
- abort=1 in any state other than IDLE: next cycle goes to IDLE with speed=0, color_enable=0, direction=0. abort has priority over all events.
- Outputs are registered; each takes its new value one cycle after the triggering input edge.
- go is level-sensitive and is ignored outside IDLE.

Optional Feature:
OBJ_PAUSE_EN: adds input obj_detect and output led_obj.
- With the macro: while obj_detect=1, speed reads 0 and the tick/sec counters freeze. The FSM state and the stored speed are held and resume when obj_detect falls. led_obj mirrors obj_detect, registered.
- Without the macro: neither port exists and there is no pause.

Test Plan:
Bench uses TICK_CYCLES=10.
1. Reset mid-LOOK -> all outputs 0 and state=0 within the same cycle (async), and state stays 0 until go.
2. go=1, green hit 5 cycles into LOOK -> speed=2, direction=1, stage_idx=1, state=GATE; then gate_in[1]=1 -> direction=1, and LOOK entered immediately after DELAY.
3. Stage 2 -> DELAY lasts exactly 100 cycles (10 s) before color_enable=1; red hit -> speed=0, done=1.
4. Stage 0 with no hits -> LOOK 30 cycles, BACKOFF 10 cycles, LOOK again, then FAULT with retry_cnt=2 and speed=0.
5. Hit and timeout in the same cycle -> advance, retry_cnt stays 0.
6. abort asserted in DONE and in DELAY -> IDLE next cycle with speed=0, direction=0; with OBJ_PAUSE_EN, obj_detect held 20 cycles in DELAY stretches the delay by 20 cycles and speed reads 0.
